// File: rtl/avalon_seq_multiplier_pkg.sv
// Shared constants for the sequential multiplier peripheral: register map,
// control/status bit positions and the core FSM state type.
package avalon_mult_pkg;

    localparam logic [2:0] ADDR_A       = 3'd0;
    localparam logic [2:0] ADDR_B       = 3'd1;
    localparam logic [2:0] ADDR_CTRL    = 3'd2;
    localparam logic [2:0] ADDR_STATUS  = 3'd3;
    localparam logic [2:0] ADDR_PROD_LO = 3'd4;
    localparam logic [2:0] ADDR_PROD_HI = 3'd5;

    localparam int CTRL_START  = 0;
    localparam int CTRL_SIGNED = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX
    } seqState_t;

    function automatic logic [31:0] statusWord(input logic busy, input logic done);
        logic [31:0] word;
        word            = '0;
        word[STAT_BUSY] = busy;
        word[STAT_DONE] = done;
        return word;
    endfunction

endpackage

// File: rtl/avalon_seq_multiplier_if.sv
// Avalon-MM slave signal bundle for the multiplier peripheral.
// The slave modport is the peripheral side, master is the bus/CPU side.
interface avalon_seq_multiplier_if;

    logic        iChipSelect_n;
    logic        iWrite_n;
    logic        iRead_n;
    logic [2:0]  iAddress;
    logic [31:0] iData;
    logic [31:0] oData;
    logic        oIrq;

    modport slave (
        input  iChipSelect_n,
        input  iWrite_n,
        input  iRead_n,
        input  iAddress,
        input  iData,
        output oData,
        output oIrq
    );

    modport master (
        output iChipSelect_n,
        output iWrite_n,
        output iRead_n,
        output iAddress,
        output iData,
        input  oData,
        input  oIrq
    );

endinterface

// File: rtl/avalon_seq_multiplier_core.sv
// Radix-2 shift-add multiplier core: magnitudes are multiplied over WIDTH
// cycles, then a single fix-up cycle applies the result sign.
//
//   state   | meaning
//   ST_IDLE | waiting for iStart; product holds last result
//   ST_RUN  | one shift-add per cycle, counter WIDTH-1 downto 0
//   ST_FIX  | negate magnitude product if operand signs differ
module seq_mult_core
    import avalon_mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 iClk,
    input  logic                 iReset,
    input  logic                 iStart,
    input  logic                 iSigned,
    input  logic [WIDTH-1:0]     iA,
    input  logic [WIDTH-1:0]     iB,
    output logic                 oBusy,
    output logic                 oDone_pulse,
    output logic [2*WIDTH-1:0]   oProduct
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    seqState_t           state;
    logic [CNT_W-1:0]    cnt;
    logic [WIDTH-1:0]    mcand;
    logic [WIDTH-1:0]    accHi;
    logic [WIDTH-1:0]    accLo;
    logic                negate;
    logic [WIDTH:0]      stepSum;
    logic [2*WIDTH-1:0]  magProd;

    // -2^(WIDTH-1) maps onto itself, which is its correct unsigned magnitude
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic s);
        return (s && x[WIDTH-1]) ? -x : x;
    endfunction

    assign stepSum = {1'b0, accHi} + (accLo[0] ? {1'b0, mcand} : '0);
    assign magProd = {accHi, accLo};

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            mcand       <= '0;
            accHi       <= '0;
            accLo       <= '0;
            negate      <= 1'b0;
            oBusy       <= 1'b0;
            oDone_pulse <= 1'b0;
            oProduct    <= '0;
        end else begin
            oDone_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (iStart) begin
                        mcand    <= magnitude(iA, iSigned);
                        accLo    <= magnitude(iB, iSigned);
                        accHi    <= '0;
                        negate   <= iSigned & (iA[WIDTH-1] ^ iB[WIDTH-1]);
                        cnt      <= CNT_W'(WIDTH - 1);
                        oBusy    <= 1'b1;
                        oProduct <= '0;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // multiplier bits shift out of accLo as product bits shift in
                    accHi <= stepSum[WIDTH:1];
                    accLo <= {stepSum[0], accLo[WIDTH-1:1]};
                    if (cnt == '0) begin
                        state <= ST_FIX;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    oProduct    <= negate ? -magProd : magProd;
                    oBusy       <= 1'b0;
                    oDone_pulse <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/avalon_seq_multiplier.sv
// Avalon-MM multiplier peripheral: operand/control registers, sticky done,
// registered read mux and level interrupt around the iterative core.
module avalon_seq_multiplier
    import avalon_mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                      iClk,
    input  logic                      iReset,
    avalon_seq_multiplier_if.slave    bus
);

    logic [WIDTH-1:0]    regA;
    logic [WIDTH-1:0]    regB;
    logic                ctrlSigned;
    logic                irqEn;
    logic                opSigned;
    logic                doneSticky;
    logic                coreBusy;
    logic                coreDone;
    logic [2*WIDTH-1:0]  coreProduct;
    logic [63:0]         product64;
    logic                wrEn;
    logic                rdEn;
    logic                startReq;
    logic                statusRead;
    logic [31:0]         rdMux;
    logic                unusedDataBits;

    assign wrEn       = !bus.iChipSelect_n && !bus.iWrite_n;
    assign rdEn       = !bus.iChipSelect_n && !bus.iRead_n && bus.iWrite_n;
    assign statusRead = rdEn && (bus.iAddress == ADDR_STATUS);
    assign startReq   = wrEn && !coreBusy && (bus.iAddress == ADDR_CTRL) && bus.iData[CTRL_START];
    assign unusedDataBits = ^bus.iData;

    // opSigned is captured at start so a later CTRL write cannot re-extend an old result
    assign product64 = opSigned ? 64'($signed(coreProduct)) : 64'(coreProduct);

    assign bus.oIrq = doneSticky & irqEn;

    seq_mult_core #(
        .WIDTH (WIDTH)
    ) uCore (
        .iClk        (iClk),
        .iReset      (iReset),
        .iStart      (startReq),
        .iSigned     (bus.iData[CTRL_SIGNED]),
        .iA          (regA),
        .iB          (regB),
        .oBusy       (coreBusy),
        .oDone_pulse (coreDone),
        .oProduct    (coreProduct)
    );

    always_comb begin
        rdMux = '0;
        case (bus.iAddress)
            ADDR_A:       rdMux = 32'(regA);
            ADDR_B:       rdMux = 32'(regB);
            ADDR_CTRL: begin
                rdMux[CTRL_SIGNED] = ctrlSigned;
                rdMux[CTRL_IRQ_EN] = irqEn;
            end
            ADDR_STATUS:  rdMux = statusWord(coreBusy, doneSticky);
            ADDR_PROD_LO: rdMux = product64[31:0];
            ADDR_PROD_HI: rdMux = product64[63:32];
            default:      rdMux = '0;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            regA       <= '0;
            regB       <= '0;
            ctrlSigned <= 1'b0;
            irqEn      <= 1'b0;
            opSigned   <= 1'b0;
            doneSticky <= 1'b0;
            bus.oData  <= '0;
        end else begin
            if (wrEn && !coreBusy) begin
                case (bus.iAddress)
                    ADDR_A:    regA <= bus.iData[WIDTH-1:0];
                    ADDR_B:    regB <= bus.iData[WIDTH-1:0];
                    ADDR_CTRL: begin
                        ctrlSigned <= bus.iData[CTRL_SIGNED];
                        irqEn      <= bus.iData[CTRL_IRQ_EN];
                    end
                    default: ;
                endcase
            end
            if (startReq) begin
                opSigned <= bus.iData[CTRL_SIGNED];
            end
            if (rdEn) begin
                bus.oData <= rdMux;
            end
            // a new start beats completion, and completion beats a STATUS read clear
            if (startReq) begin
                doneSticky <= 1'b0;
            end else if (coreDone) begin
                doneSticky <= 1'b1;
            end else if (statusRead) begin
                doneSticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_avalon_seq_multiplier.sv
// Bench for the multiplier peripheral: a 16-bit and a 32-bit instance share one
// bus stimulus and are checked every cycle against a transaction-level model.
module tb_avalon_seq_multiplier;

    logic        clk;
    logic        rst;
    logic        tbCs;
    logic        tbWr;
    logic        tbRd;
    logic [2:0]  tbAddr;
    logic [31:0] tbData;

    int tests = 0;
    int fails = 0;

    avalon_seq_multiplier_if busN ();
    avalon_seq_multiplier_if busW ();

    assign busN.iChipSelect_n = tbCs;
    assign busN.iWrite_n      = tbWr;
    assign busN.iRead_n       = tbRd;
    assign busN.iAddress      = tbAddr;
    assign busN.iData         = tbData;
    assign busW.iChipSelect_n = tbCs;
    assign busW.iWrite_n      = tbWr;
    assign busW.iRead_n       = tbRd;
    assign busW.iAddress      = tbAddr;
    assign busW.iData         = tbData;

    avalon_seq_multiplier #(.WIDTH(16)) dutN (.iClk(clk), .iReset(rst), .bus(busN.slave));
    avalon_seq_multiplier #(.WIDTH(32)) dutW (.iClk(clk), .iReset(rst), .bus(busW.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          widthOf[2] = '{16, 32};
    bit [31:0]   mA[2], mB[2], mData[2];
    bit          mSig[2], mIrq[2], mDone[2], mBusy[2];
    bit [63:0]   mProd[2], mRes[2];
    longint      mStart[2];
    longint      edgeNo = 0;
    bit          modelLive = 0;

    function automatic bit [63:0] refProduct(bit [31:0] a, bit [31:0] b, bit s, int w);
        longint sa, sb;
        bit [63:0] ua, ub;
        if (s) begin
            sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
            sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
            return 64'(sa * sb);
        end
        ua = {32'b0, a};
        ub = {32'b0, b};
        return ua * ub;
    endfunction

    task automatic modelEdge(input int k);
        bit wrEn, rdEn, start, finish, doneSet, busyOld;
        bit [31:0] mask;
        int w;
        w = widthOf[k];
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        if (rst) begin
            mA[k] = 0; mB[k] = 0; mData[k] = 0; mSig[k] = 0; mIrq[k] = 0;
            mDone[k] = 0; mBusy[k] = 0; mProd[k] = 0; mRes[k] = 0; mStart[k] = -1;
            return;
        end
        wrEn    = !tbCs && !tbWr;
        rdEn    = !tbCs && !tbRd && tbWr;
        busyOld = mBusy[k];
        start   = wrEn && tbAddr == 3'd2 && tbData[0] && !busyOld;
        finish  = busyOld && edgeNo == mStart[k] + w + 1;
        doneSet = !busyOld && mStart[k] >= 0 && edgeNo == mStart[k] + w + 2;
        if (rdEn) begin
            case (tbAddr)
                3'd0:    mData[k] = mA[k];
                3'd1:    mData[k] = mB[k];
                3'd2:    mData[k] = {29'b0, mIrq[k], mSig[k], 1'b0};
                3'd3:    mData[k] = {30'b0, mDone[k], busyOld};
                3'd4:    mData[k] = mProd[k][31:0];
                3'd5:    mData[k] = mProd[k][63:32];
                default: mData[k] = 0;
            endcase
        end
        if (rdEn && tbAddr == 3'd3) mDone[k] = 0;
        if (doneSet) mDone[k] = 1;
        if (finish) begin
            mBusy[k] = 0;
            mProd[k] = mRes[k];
        end
        if (wrEn && !busyOld) begin
            case (tbAddr)
                3'd0: mA[k] = tbData & mask;
                3'd1: mB[k] = tbData & mask;
                3'd2: begin mSig[k] = tbData[1]; mIrq[k] = tbData[2]; end
                default: ;
            endcase
        end
        if (start) begin
            mRes[k]   = refProduct(mA[k], mB[k], tbData[1], w);
            mBusy[k]  = 1;
            mProd[k]  = 0;
            mDone[k]  = 0;
            mStart[k] = edgeNo;
        end
    endtask

    always @(posedge clk) begin
        modelEdge(0);
        modelEdge(1);
        edgeNo++;
        modelLive = 1;
    end

    always @(negedge clk) begin
        if (modelLive) begin
            check("oData_w16", busN.oData, mData[0]);
            check("oIrq_w16", 32'(busN.oIrq), 32'(mDone[0] & mIrq[0]));
            check("oData_w32", busW.oData, mData[1]);
            check("oIrq_w32", 32'(busW.oIrq), 32'(mDone[1] & mIrq[1]));
        end
    end

    // ---------------- bus tasks (entered/left just after a falling edge) ----------------
    task automatic drive(input bit cs, input bit wr, input bit rd, input bit [2:0] a, input bit [31:0] d);
        tbCs = cs; tbWr = wr; tbRd = rd; tbAddr = a; tbData = d;
        @(negedge clk); #1;
        tbCs = 1'b1; tbWr = 1'b1; tbRd = 1'b1;
    endtask

    task automatic busWrite(input bit [2:0] a, input bit [31:0] d);
        drive(1'b0, 1'b0, 1'b1, a, d);
    endtask

    task automatic busRead(input bit [2:0] a, output logic [31:0] vN, output logic [31:0] vW);
        drive(1'b0, 1'b1, 1'b0, a, 32'h0);
        vN = busN.oData;
        vW = busW.oData;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic waitDone(input bit chkLat);
        int kN, kW;
        kN = -1; kW = -1;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            if (kN < 0 && busN.oIrq) kN = k;
            if (kW < 0 && busW.oIrq) kW = k;
            if (kN >= 0 && kW >= 0) break;
        end
        if (kN < 0 || kW < 0) begin
            tests++; fails++;
            $display("FAIL done_timeout: irq cycles w16=%0d w32=%0d, required 18 and 34", kN, kW);
        end else if (chkLat) begin
            check("latency_w16", 32'(kN), 32'd18);
            check("latency_w32", 32'(kW), 32'd34);
        end
        @(negedge clk); #1;
    endtask

    task automatic doOp(input bit [31:0] a, input bit [31:0] b, input bit [31:0] ctrl);
        busWrite(3'd0, a);
        busWrite(3'd1, b);
        busWrite(3'd2, ctrl);
        waitDone(1'b1);
    endtask

    task automatic readProd(input string name, input bit [31:0] loN, input bit [31:0] hiN,
                            input bit [31:0] loW, input bit [31:0] hiW);
        logic [31:0] vN, vW;
        busRead(3'd4, vN, vW);
        check({name, "_lo_w16"}, vN, loN);
        check({name, "_lo_w32"}, vW, loW);
        busRead(3'd5, vN, vW);
        check({name, "_hi_w16"}, vN, hiN);
        check({name, "_hi_w32"}, vW, hiW);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 1ms");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] vN, vW;
        int r;
        bit [2:0] a3;
        bit [31:0] d;

        rst = 1'b1; tbCs = 1'b1; tbWr = 1'b1; tbRd = 1'b1; tbAddr = 3'd0; tbData = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b0;

        busRead(3'd3, vN, vW);
        check("reset_status_w16", vN, 32'h0);
        check("reset_status_w32", vW, 32'h0);
        busRead(3'd4, vN, vW);
        check("reset_prod_w16", vN, 32'h0);

        // unsigned full-scale
        doOp(32'hFFFF_FFFF, 32'h0000_FFFF, 32'h5);
        readProd("uns", 32'hFFFE_0001, 32'h0, 32'hFFFF_0001, 32'h0000_FFFE);
        busRead(3'd3, vN, vW);
        check("sticky_status_w16", vN, 32'h2);
        check("sticky_status_w32", vW, 32'h2);
        busRead(3'd3, vN, vW);
        check("cleared_status_w16", vN, 32'h0);
        check("cleared_status_w32", vW, 32'h0);

        // signed cases
        doOp(32'hFFFF_FFFD, 32'h0000_0005, 32'h7);
        readProd("neg15", 32'hFFFF_FFF1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 32'hFFFF_FFFF);
        doOp(32'h0000_8000, 32'h0000_8000, 32'h7);
        readProd("min16", 32'h4000_0000, 32'h0, 32'h4000_0000, 32'h0);
        doOp(32'h8000_0000, 32'h8000_0000, 32'h7);
        readProd("min32", 32'h0, 32'h0, 32'h0, 32'h4000_0000);

        // 32-bit unsigned carry into the high word
        doOp(32'hFFFF_FFFF, 32'h0000_0002, 32'h5);
        readProd("carry", 32'h0001_FFFE, 32'h0, 32'hFFFF_FFFE, 32'h1);

        // writes and restart while busy are ignored
        busWrite(3'd0, 32'h3);
        busWrite(3'd1, 32'h4);
        busWrite(3'd2, 32'h5);
        busWrite(3'd0, 32'h7);
        busWrite(3'd2, 32'h3);
        busRead(3'd3, vN, vW);
        check("busy_status_w16", vN, 32'h1);
        check("busy_status_w32", vW, 32'h1);
        waitDone(1'b0);
        readProd("protect", 32'd12, 32'h0, 32'd12, 32'h0);
        busRead(3'd0, vN, vW);
        check("protect_a_w16", vN, 32'h3);
        busRead(3'd2, vN, vW);
        check("protect_ctrl_w16", vN, 32'h4);

        // STATUS read on the completion edge keeps done
        busWrite(3'd0, 32'h2);
        busWrite(3'd1, 32'h3);
        busWrite(3'd2, 32'h5);
        idle(16);
        busRead(3'd3, vN, vW);
        check("collide_status_w16", vN, 32'h1);
        idle(1);
        check("collide_irq_w16", 32'(busN.oIrq), 32'h1);
        busRead(3'd3, vN, vW);
        check("after_collide_status_w16", vN, 32'h2);
        check("irq_cleared_w16", 32'(busN.oIrq), 32'h0);
        idle(20);

        // reset mid-run
        busWrite(3'd0, 32'h1234);
        busWrite(3'd1, 32'h55);
        busWrite(3'd2, 32'h1);
        idle(5);
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        check("rst_odata_w16", busN.oData, 32'h0);
        check("rst_odata_w32", busW.oData, 32'h0);
        busRead(3'd3, vN, vW);
        check("rst_status_w16", vN, 32'h0);
        busRead(3'd0, vN, vW);
        check("rst_a_w32", vW, 32'h0);
        busRead(3'd4, vN, vW);
        check("rst_prod_w16", vN, 32'h0);
        doOp(32'd6, 32'd7, 32'h5);
        readProd("fresh", 32'd42, 32'h0, 32'd42, 32'h0);

        // randomized traffic
        for (int i = 0; i < 700; i++) begin
            r  = $urandom_range(0, 19);
            a3 = 3'($urandom_range(0, 7));
            d  = $urandom;
            if ($urandom_range(0, 249) == 0) begin
                rst = 1'b1;
                @(negedge clk); #1;
                rst = 1'b0;
            end else if (r < 5) begin
                if (r < 2) a3 = 3'd2;
                if (a3 == 3'd2 && r == 0) d[0] = 1'b1;
                busWrite(a3, d);
            end else if (r < 11) begin
                drive(1'b0, 1'b1, 1'b0, a3, d);
            end else if (r == 11) begin
                drive(1'b0, 1'b0, 1'b0, a3, d);
            end else if (r == 12) begin
                drive(1'b1, 1'b0, 1'b0, a3, d);
            end else if (r == 13) begin
                d = ($urandom_range(0, 1) != 0) ? 32'h0000_8000 : 32'h8000_0000;
                busWrite(3'($urandom_range(0, 1)), d);
            end else begin
                idle(1);
            end
        end
        idle(60);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
